// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared constants and FSM state type for the instruction fetch block
package instr_mem_pkg;
  localparam logic [31:0] NOP_INSTR = '0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: synchronous read-first RAM, one read port and one write port
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic rd_ok, wr_ok;
  assign rd_ok   = rd_en && ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_data = rd_q;
  // both updates are non-blocking, so a same-address read sees the old word
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_data;
    if (rd_ok) rd_q <= mem[rd_addr[IW-1:0]];
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: valid/ready instruction fetch port over a program-loadable RAM
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 14,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [31:0]       fetch_cnt
);
  state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic accept, hs, in_range;
  logic [DATA_W-1:0] rd_data;
  assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign rsp_valid = state_q == S_RESP;
  assign req_ready = state_q == S_IDLE || (rsp_valid && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign hs        = rsp_valid && rsp_ready;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_instr = (rsp_valid && !err_q) ? rd_data : DATA_W'(NOP_INSTR);
  assign fetch_cnt = cnt_q;
  // the RAM read register is loaded only on accept, so it holds the response word
  instr_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .rd_en(accept && in_range), .rd_addr(req_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 32'(hs);
    if (accept) begin
      state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
      wcnt_d  = 3'(WAIT_STATES);
      err_d   = !in_range;
    end else if (hs) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      state_d = wcnt_q == 3'd1 ? S_RESP : S_WAIT;
      wcnt_d  = wcnt_q - 3'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
